tiny_cpu_param: RTL and testbench

//  Parametrised successor to the fixed 8-bit, two-register TinyCPU.
//  - Register file of NREG registers, each W bits wide.
//  - Single-cycle ALU and a flags register.
//  - Valid/ready instruction handshake.
//  - Optional multi-cycle shift-add multiplier.

---
 rtl/tiny_cpu_pkg.sv | 30 +++
 rtl/tiny_cpu_param_mul_seq.sv | 64 ++++++
 rtl/tiny_cpu_param.sv | 193 +++++++++++++++++++
 tb/tb_tiny_cpu_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny_cpu_param slice.
//   - Opcode constants OP_CLR..OP_MUL (4-bit op field of the instruction word)
//   - Flag bit positions inside the 4-bit Flags bus {GT, EQ, C, Z}
//   - Control state encoding (IDLE accepts instructions, MUL waits on the multiplier)
package tiny_cpu_pkg;

  localparam logic [3:0] OP_CLR  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_MOVR = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  localparam int F_Z  = 0;
  localparam int F_C  = 1;
  localparam int F_EQ = 2;
  localparam int F_GT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/tiny_cpu_param_mul_seq.sv
// tiny_mul_seq: sequential shift-add multiplier, W iterations per product.
// Only compiled when TINY_CPU_MUL_EN is defined.
// Ports:
//   clk      in  1    rising-edge clock
//   reset    in  1    synchronous active-high reset, aborts a running product
//   start    in  1    latch a/b at this edge and begin multiplying
//   a, b     in  W    operands
//   done     out 1    product is final at the coming edge (combinational)
//   product  out 2W   running product including the current partial step
`ifdef TINY_CPU_MUL_EN
module tiny_mul_seq #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W);

  logic           busy;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_nxt;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  // The last partial product is folded in combinationally so the caller can
  // capture the final value on the W-th edge after start.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
    done    = busy && (cnt == CW'(W - 1));
    product = acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/tiny_cpu_param.sv
// tiny_cpu_param: parametrised TinyCPU with NREG x W register file,
// single-cycle ALU, flags register and valid/ready instruction input.
// Build option: define TINY_CPU_MUL_EN to add the W-cycle shift-add multiplier
// (opcode 1011); without it that opcode is a NOP and InReady only drops in reset.
// Ports:
//   Clk          in  1           rising-edge clock
//   Reset        in  1           synchronous active-high reset
//   In           in  4+2*RW+W    {op[3:0], rd[RW-1:0], rs[RW-1:0], imm[W-1:0]}
//   InValid      in  1           In holds a valid instruction
//   InReady      out 1           instruction accepted on InValid & InReady
//   Result       out W           result register
//   Flags        out 4           {GT, EQ, C, Z}
//   ResultValid  out 1           pulse after an edge that updated Result/Flags
import tiny_cpu_pkg::*;

module tiny_cpu_param #(
  parameter int W    = 8,
  parameter int NREG = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [4+2*$clog2(NREG)+W-1:0]   In,
  input  logic                            InValid,
  output logic                            InReady,
  output logic [W-1:0]                    Result,
  output logic [3:0]                      Flags,
  output logic                            ResultValid
);

  localparam int RW = $clog2(NREG);

  logic [3:0]    op;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs;
  logic [W-1:0]  imm;

  assign op  = In[4+2*RW+W-1 -: 4];
  assign rd  = In[2*RW+W-1 -: RW];
  assign rs  = In[RW+W-1 -: RW];
  assign imm = In[W-1:0];

  logic [W-1:0] regs [NREG];
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         accept;

  state_t state;
  state_t state_nxt;

  assign opa    = regs[rd];
  assign opb    = regs[rs];
  assign accept = InValid && InReady;

`ifdef TINY_CPU_MUL_EN
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;

  tiny_mul_seq #(.W(W)) u_mul (
    .clk     (Clk),
    .reset   (Reset),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_prod)
  );
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    InReady   = !Reset && (state == IDLE);
`ifdef TINY_CPU_MUL_EN
    mul_start = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef TINY_CPU_MUL_EN
        if (accept && (op == OP_MUL)) begin
          state_nxt = MUL;
          mul_start = 1'b1;
        end
`endif
      end
      MUL: begin
`ifdef TINY_CPU_MUL_EN
        if (mul_done) state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- single-cycle ALU ----------------
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         wr_res;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    wr_res  = 1'b0;
    case (op)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
        wr_res = 1'b1;
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow.
        {alu_c, alu_res} = {1'b0, opa} - {1'b0, opb};
        wr_res = 1'b1;
      end
      OP_SHR: begin
        alu_res = opa >> 1;
        alu_c   = opa[0];
        wr_res  = 1'b1;
      end
      OP_SHL: begin
        alu_res = opa << 1;
        alu_c   = opa[W-1];
        wr_res  = 1'b1;
      end
      OP_XOR: begin
        alu_res = opa ^ opb;
        wr_res  = 1'b1;
      end
      OP_AND: begin
        alu_res = opa & opb;
        wr_res  = 1'b1;
      end
      OP_OR: begin
        alu_res = opa | opb;
        wr_res  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- architectural state ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs        <= '{default: '0};
      Result      <= '0;
      Flags       <= '0;
      ResultValid <= 1'b0;
    end else begin
      ResultValid <= 1'b0;
      if (accept) begin
        case (op)
          OP_CLR: begin
            regs        <= '{default: '0};
            Result      <= '0;
            Flags       <= '0;
            ResultValid <= 1'b1;
          end
          OP_LDI:  regs[rd] <= imm;
          OP_MOVR: regs[rd] <= Result;
          OP_CMP: begin
            Flags[F_EQ] <= (opa == opb);
            Flags[F_GT] <= (opa > opb);
            ResultValid <= 1'b1;
          end
          default: begin
            if (wr_res) begin
              Result      <= alu_res;
              Flags[F_Z]  <= (alu_res == '0);
              Flags[F_C]  <= alu_c;
              ResultValid <= 1'b1;
            end
          end
        endcase
      end
`ifdef TINY_CPU_MUL_EN
      // No instruction is accepted in MUL, so this never collides with the case above.
      if ((state == MUL) && mul_done) begin
        Result      <= mul_prod[W-1:0];
        Flags[F_Z]  <= (mul_prod[W-1:0] == '0);
        Flags[F_C]  <= |mul_prod[2*W-1:W];
        ResultValid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_tiny_cpu_param.sv
// Directed testbench for tiny_cpu_param (W=8, NREG=4): table of single-cycle
// instructions with hand-computed results, plus sequences for idle input,
// multiplier stalls (TINY_CPU_MUL_EN) and reset in the middle of an operation.
module tb_tiny_cpu_param;

  localparam int W    = 8;
  localparam int NREG = 4;

  localparam logic [3:0] CLR  = 4'h0;
  localparam logic [3:0] LDI  = 4'h1;
  localparam logic [3:0] MOVR = 4'h2;
  localparam logic [3:0] ADD  = 4'h3;
  localparam logic [3:0] SUB  = 4'h4;
  localparam logic [3:0] SHR  = 4'h5;
  localparam logic [3:0] SHL  = 4'h6;
  localparam logic [3:0] XOR  = 4'h7;
  localparam logic [3:0] AND  = 4'h8;
  localparam logic [3:0] OR   = 4'h9;
  localparam logic [3:0] CMP  = 4'hA;
  localparam logic [3:0] MULT = 4'hB;
  localparam logic [3:0] UNDF = 4'hF;

  logic        Clk     = 1'b0;
  logic        Reset   = 1'b1;
  logic [15:0] In      = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [7:0]  Result;
  logic [3:0]  Flags;
  logic        ResultValid;

  int nchecks = 0;
  int nerrors = 0;

  tiny_cpu_param #(.W(W), .NREG(NREG)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .In          (In),
    .InValid     (InValid),
    .InReady     (InReady),
    .Result      (Result),
    .Flags       (Flags),
    .ResultValid (ResultValid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] res;
    logic [3:0] flg;
    logic       rv;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input string name, input logic [3:0] op, input logic [1:0] rd,
                   input logic [1:0] rs, input logic [7:0] imm, input logic [7:0] res,
                   input logic [3:0] flg, input logic rv);
    vec_t e;
    e.name = name; e.op = op; e.rd = rd; e.rs = rs; e.imm = imm;
    e.res = res; e.flg = flg; e.rv = rv;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [7:0] r,
                            input logic [3:0] f, input logic rv);
    chk({name, " result"}, 32'(Result), 32'(r));
    chk({name, " flags"}, 32'(Flags), 32'(f));
    chk({name, " resultvalid"}, 32'(ResultValid), 32'(rv));
  endtask

  // Present one instruction at a negedge; returns 1 ns after the accepting edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm);
    @(negedge Clk);
    In = {op, rd, rs, imm};
    InValid = 1'b1;
    #1 chk({name, " inready"}, 32'(InReady), 32'(1));
    @(posedge Clk);
    #1 InValid = 1'b0;
  endtask

  // Counts cycles with InReady low, sampled at negedges, with a bound.
  task automatic wait_ready(output int stalls);
    stalls = 0;
    @(negedge Clk);
    #1;
    while (!InReady && stalls < 40) begin
      stalls++;
      @(negedge Clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", nchecks);
    $fatal(1);
  end

  initial begin
    int stalls;

    // table: name, op, rd, rs, imm, expected Result, Flags {GT,EQ,C,Z}, ResultValid
    v("clr",       CLR,  0, 0, 8'h00, 8'h00, 4'b0000, 1);
    v("ldi_r0",    LDI,  0, 0, 8'h07, 8'h00, 4'b0000, 0);
    v("ldi_r1",    LDI,  1, 0, 8'h08, 8'h00, 4'b0000, 0);
    v("add_r0r1",  ADD,  0, 1, 8'h00, 8'h0F, 4'b0000, 1);
    v("xor_r0r1",  XOR,  0, 1, 8'h00, 8'h0F, 4'b0000, 1);
    v("cmp_r0r1",  CMP,  0, 1, 8'h00, 8'h0F, 4'b0000, 1);
    v("cmp_r1r0",  CMP,  1, 0, 8'h00, 8'h0F, 4'b1000, 1);
    v("shr_r0",    SHR,  0, 0, 8'h00, 8'h03, 4'b1010, 1);
    v("movr_r1",   MOVR, 1, 0, 8'h00, 8'h03, 4'b1010, 0);
    v("add_r1r1",  ADD,  1, 1, 8'h00, 8'h06, 4'b1000, 1);
    v("ldi_r2",    LDI,  2, 0, 8'hFF, 8'h06, 4'b1000, 0);
    v("ldi_r3",    LDI,  3, 0, 8'h01, 8'h06, 4'b1000, 0);
    v("add_wrap",  ADD,  2, 3, 8'h00, 8'h00, 4'b1011, 1);
    v("sub_borrow",SUB,  3, 2, 8'h00, 8'h02, 4'b1010, 1);
    v("cmp_r2r2",  CMP,  2, 2, 8'h00, 8'h02, 4'b0110, 1);
    v("shl_r2",    SHL,  2, 0, 8'h00, 8'hFE, 4'b0110, 1);
    v("and_r2r3",  AND,  2, 3, 8'h00, 8'h01, 4'b0100, 1);
    v("or_r0r3",   OR,   0, 3, 8'h00, 8'h07, 4'b0100, 1);
    v("sub_r0r0",  SUB,  0, 0, 8'h00, 8'h00, 4'b0101, 1);
    v("undef_op",  UNDF, 1, 2, 8'hFF, 8'h00, 4'b0101, 0);
    v("shl_r3",    SHL,  3, 0, 8'h00, 8'h02, 4'b0100, 1);

    // reset state
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst inready", 32'(InReady), 32'(0));
    expect_out("rst", 8'h00, 4'b0000, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    #1 chk("post_rst inready", 32'(InReady), 32'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm);
      expect_out(vecs[i].name, vecs[i].res, vecs[i].flg, vecs[i].rv);
    end
    // regs now: r0=07 r1=03 r2=FF r3=01

    // InValid low with random In: nothing may happen
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      In = 16'($urandom);
      @(posedge Clk);
      #1 chk("idle resultvalid", 32'(ResultValid), 32'(0));
    end
    expect_out("idle end", 8'h02, 4'b0100, 1'b0);
    issue("add_r0r3", ADD, 0, 3, 8'h00);
    expect_out("add_r0r3", 8'h08, 4'b0100, 1'b1);

`ifdef TINY_CPU_MUL_EN
    issue("ldi_13", LDI, 0, 0, 8'd13);
    issue("ldi_11", LDI, 1, 0, 8'd11);
    issue("mul13x11", MULT, 0, 1, 8'h00);
    expect_out("mul13x11 start", 8'h08, 4'b0100, 1'b0);
    // hold an ADD on the input throughout the stall
    In = {ADD, 2'd0, 2'd1, 8'h00};
    InValid = 1'b1;
    wait_ready(stalls);
    chk("mul13x11 stall cycles", 32'(stalls), 32'(8));
    expect_out("mul13x11 done", 8'h8F, 4'b0100, 1'b1);
    @(posedge Clk);
    #1 InValid = 1'b0;
    expect_out("held add", 8'h18, 4'b0100, 1'b1);

    issue("ldi_r0_10", LDI, 0, 0, 8'h10);
    issue("ldi_r1_10", LDI, 1, 0, 8'h10);
    issue("mul16x16", MULT, 0, 1, 8'h00);
    wait_ready(stalls);
    chk("mul16x16 stall cycles", 32'(stalls), 32'(8));
    expect_out("mul16x16 done", 8'h00, 4'b0111, 1'b1);
`else
    issue("mul_nop", MULT, 0, 3, 8'h00);
    expect_out("mul_nop", 8'h08, 4'b0100, 1'b0);
    @(negedge Clk);
    #1 chk("mul_nop inready", 32'(InReady), 32'(1));
`endif

    // reset three cycles into a MUL
    issue("mul_abort", MULT, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1 chk("mul_abort resultvalid", 32'(ResultValid), 32'(0));
    end
    Reset = 1'b1;
    #1 chk("abort rst inready", 32'(InReady), 32'(0));
    @(posedge Clk);
    #1 expect_out("abort rst", 8'h00, 4'b0000, 1'b0);
    @(negedge Clk);
    #1 chk("abort rst inready2", 32'(InReady), 32'(0));
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Reset = 1'b0;
    In = {LDI, 2'd2, 2'd0, 8'h55};
    InValid = 1'b1;
    #1 chk("first cycle inready", 32'(InReady), 32'(1));
    @(posedge Clk);
    #1 InValid = 1'b0;
    expect_out("ldi after rst", 8'h00, 4'b0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      #1 chk("post_abort resultvalid", 32'(ResultValid), 32'(0));
    end
    issue("add_cleared", ADD, 0, 1, 8'h00);
    expect_out("add_cleared", 8'h00, 4'b0001, 1'b1);
    issue("add_r2r3", ADD, 2, 3, 8'h00);
    expect_out("add_r2r3", 8'h55, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
